// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32IM memory stage: width codes and FSM states.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_BUSY = 1'b1
  } mem_state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_align_unit.sv
// Combinational lane steering for stores plus the alignment check used by
// both loads and stores.
module store_align_unit
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = rs2_i;
    misaligned_o = 1'b0;
    case (func3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{rs2_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      F3_W: begin
        misaligned_o = |addr_lo_i;
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = rs2_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: drives the data-memory req/ack bus, stalls the pipeline while
// an access is outstanding and registers the MEM/WB values for writeback.
module mem_access_unit
  import rv32_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  EX_FUNC3,
  input  logic        EX_MEM_READ,
  input  logic        EX_MEM_WRITE,
  input  logic        EX_WRITE_ENABLE,
  input  logic        EX_DATA_MEM_SELECT,
  input  logic [31:0] EX_ALU_RESULT,
  input  logic [31:0] EX_JAL_SELECTED,
  input  logic [31:0] EX_RS2_DATA,
  input  logic [4:0]  EX_RD,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        STALL,
  output logic        MISALIGN,
  output logic [2:0]  MEM_FUNC3,
  output logic        MEM_WRITE_ENABLE,
  output logic        MEM_DATA_MEM_SELECT,
  output logic [31:0] MEM_JAL_SELECTED,
  output logic [31:0] MEM_DATA_OUT,
  output logic [4:0]  MEM_RD
);

  mem_state_t  state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        misalign_q, misalign_d;
  logic [2:0]  mem_func3_q, mem_func3_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_dsel_q, mem_dsel_d;
  logic [31:0] mem_jal_q, mem_jal_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [4:0]  mem_rd_q, mem_rd_d;

  logic        mem_op;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] load_shifted;

  store_align_unit u_store_align (
    .func3_i      (EX_FUNC3),
    .addr_lo_i    (EX_ALU_RESULT[1:0]),
    .rs2_i        (EX_RS2_DATA),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .misaligned_o (misaligned)
  );

  // A simultaneous read+write request is treated as a store.
  assign mem_op       = EX_MEM_READ | EX_MEM_WRITE;
  assign is_store     = EX_MEM_WRITE;
  assign load_shifted = DMEM_RDATA >> {EX_ALU_RESULT[1:0], 3'b000};

  assign STALL = ((state_q == MS_IDLE) && mem_op && !misaligned) ||
                 ((state_q == MS_BUSY) && !DMEM_ACK);

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    misalign_d   = 1'b0;
    mem_func3_d  = 3'b000;
    mem_we_d     = 1'b0;
    mem_dsel_d   = 1'b0;
    mem_jal_d    = 32'h0;
    mem_data_d   = 32'h0;
    mem_rd_d     = 5'd0;
    case (state_q)
      MS_IDLE: begin
        if (!mem_op) begin
          mem_func3_d = EX_FUNC3;
          mem_we_d    = EX_WRITE_ENABLE;
          mem_dsel_d  = EX_DATA_MEM_SELECT;
          mem_jal_d   = EX_JAL_SELECTED;
          mem_rd_d    = EX_RD;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          state_d      = MS_BUSY;
          dmem_req_d   = 1'b1;
          dmem_we_d    = is_store;
          dmem_addr_d  = word_addr(EX_ALU_RESULT);
          dmem_be_d    = is_store ? align_be : 4'b1111;
          dmem_wdata_d = is_store ? align_wdata : 32'h0;
        end
      end
      MS_BUSY: begin
        if (DMEM_ACK) begin
          state_d     = MS_IDLE;
          dmem_req_d  = 1'b0;
          mem_func3_d = EX_FUNC3;
          mem_we_d    = EX_WRITE_ENABLE;
          mem_dsel_d  = EX_DATA_MEM_SELECT;
          mem_jal_d   = EX_JAL_SELECTED;
          mem_rd_d    = EX_RD;
          mem_data_d  = is_store ? 32'h0 : load_shifted;
        end
      end
      default: begin
        state_d    = MS_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= MS_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_be_q    <= 4'h0;
      dmem_wdata_q <= 32'h0;
      misalign_q   <= 1'b0;
      mem_func3_q  <= 3'b000;
      mem_we_q     <= 1'b0;
      mem_dsel_q   <= 1'b0;
      mem_jal_q    <= 32'h0;
      mem_data_q   <= 32'h0;
      mem_rd_q     <= 5'd0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      misalign_q   <= misalign_d;
      mem_func3_q  <= mem_func3_d;
      mem_we_q     <= mem_we_d;
      mem_dsel_q   <= mem_dsel_d;
      mem_jal_q    <= mem_jal_d;
      mem_data_q   <= mem_data_d;
      mem_rd_q     <= mem_rd_d;
    end
  end

  assign DMEM_REQ            = dmem_req_q;
  assign DMEM_WE             = dmem_we_q;
  assign DMEM_ADDR           = dmem_addr_q;
  assign DMEM_BE             = dmem_be_q;
  assign DMEM_WDATA          = dmem_wdata_q;
  assign MISALIGN            = misalign_q;
  assign MEM_FUNC3           = mem_func3_q;
  assign MEM_WRITE_ENABLE    = mem_we_q;
  assign MEM_DATA_MEM_SELECT = mem_dsel_q;
  assign MEM_JAL_SELECTED    = mem_jal_q;
  assign MEM_DATA_OUT        = mem_data_q;
  assign MEM_RD              = mem_rd_q;

endmodule
